viterbi: RTL and testbench

//   Hard-decision Viterbi decoder for a terminated rate-1/2 K=3 conv. code (g0=111, g1=101).

---
 rtl/viterbi_pkg.sv | 30 +++
 rtl/viterbi_acs.sv | 28 ++
 rtl/viterbi.sv | 138 +++++++++++++
 tb/tb_viterbi.sv | 121 ++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, FSM state type and trellis helper functions for the
// K=3, rate-1/2 (g0=111, g1=101) hard-decision Viterbi decoder.
package viterbi_pkg;
  localparam int N_SYM    = 14;           // symbol pairs per block
  localparam int N_STATE  = 4;            // 2^(K-1) trellis states
  localparam int METRIC_W = 6;            // path metric width
  localparam int CW_W     = 2 * N_SYM;    // codeword width

  localparam logic [METRIC_W-1:0] METRIC_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACS,
    ST_FINISH,
    ST_DONE
  } state_e;

  // Encoder output for state s={u[n-1],u[n-2]} and input bit u: {g0,g1}.
  function automatic logic [1:0] exp_pair(input logic [1:0] s, input logic u);
    return {u ^ s[1] ^ s[0], u ^ s[0]};
  endfunction

  // Hamming distance between two 2-bit symbols (0..2).
  function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction
endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis next-state.
//   i_metric0/i_bm0 : metric + branch metric via the lower-index predecessor
//   i_metric1/i_bm1 : metric + branch metric via the higher-index predecessor
//   o_metric        : surviving metric, saturated at METRIC_MAX
//   o_dec           : 1 when predecessor 1 wins (ties go to predecessor 0)
module viterbi_acs
  import viterbi_pkg::*;
(
  input  logic [METRIC_W-1:0] i_metric0,
  input  logic [METRIC_W-1:0] i_metric1,
  input  logic [1:0]          i_bm0,
  input  logic [1:0]          i_bm1,
  output logic [METRIC_W-1:0] o_metric,
  output logic                o_dec
);
  logic [METRIC_W:0]   w_sum0, w_sum1;
  logic [METRIC_W-1:0] w_cand0, w_cand1;

  // One extra bit of headroom so the saturation test sees the carry.
  assign w_sum0  = {1'b0, i_metric0} + {{(METRIC_W-1){1'b0}}, i_bm0};
  assign w_sum1  = {1'b0, i_metric1} + {{(METRIC_W-1){1'b0}}, i_bm1};
  assign w_cand0 = w_sum0[METRIC_W] ? METRIC_MAX : w_sum0[METRIC_W-1:0];
  assign w_cand1 = w_sum1[METRIC_W] ? METRIC_MAX : w_sum1[METRIC_W-1:0];

  // Strict less-than keeps ties on predecessor 0.
  assign o_dec    = (w_cand1 < w_cand0);
  assign o_metric = o_dec ? w_cand1 : w_cand0;
endmodule

// File: rtl/viterbi.sv
// Hard-decision Viterbi decoder for a terminated 14-symbol block of the
// K=3 rate-1/2 code (g0=111, g1=101). Register-exchange survivors.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   in        : received codeword, pair k = in[27-2k -: 2], MSB = g0
//   data      : decoded bits, data[13] = first bit (last two are tail zeros)
//   best_path : re-encoded codeword of the surviving path
//   done      : high while data/best_path belong to the captured block
// A block is (re)decoded whenever `in` differs from the last captured block,
// checked only in IDLE/DONE. An all-zero block right after reset matches the
// reset value of the capture register and is therefore not decoded.
module viterbi
  import viterbi_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [CW_W-1:0] in,
  output logic [N_SYM-1:0] data,
  output logic [CW_W-1:0] best_path,
  output logic            done
);
  state_e r_state, w_next;

  logic [CW_W-1:0]                      r_in_tmp;
  logic [3:0]                           r_step;
  logic [N_STATE-1:0][METRIC_W-1:0]     r_metric, w_metric;
  logic [N_STATE-1:0][N_SYM-1:0]        r_surv_data, w_surv_data;
  logic [N_STATE-1:0][CW_W-1:0]         r_surv_code, w_surv_code;
  logic [N_STATE-1:0]                   w_dec;

  logic                 w_new_blk;
  logic [CW_W-1:0]      w_rx_sh;
  logic [1:0]           w_rx;
  logic [N_SYM-1:0]     w_dmask;
  logic [CW_W-1:0]      w_cmask;

  assign w_new_blk = (in != r_in_tmp);

  // Received pair for this step: shift step i's pair up to the top.
  assign w_rx_sh = r_in_tmp << {r_step, 1'b0};
  assign w_rx    = w_rx_sh[CW_W-1 -: 2];

  // Position of step i inside the survivor registers.
  assign w_dmask = {1'b1, {(N_SYM-1){1'b0}}} >> r_step;
  assign w_cmask = {2'b11, {(CW_W-2){1'b0}}} >> {r_step, 1'b0};

  // Next state ns={u,s1}; its predecessors are {s1,0} and {s1,1}.
  for (genvar g = 0; g < N_STATE; g++) begin : g_acs
    localparam logic [1:0] NS = 2'(g);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};
    localparam logic       U  = NS[1];

    logic [1:0]       w_e0, w_e1, w_esel;
    logic [1:0]       w_bm0, w_bm1;
    logic [N_SYM-1:0] w_sel_d;
    logic [CW_W-1:0]  w_sel_c, w_cpair;

    assign w_e0  = exp_pair(P0, U);
    assign w_e1  = exp_pair(P1, U);
    assign w_bm0 = hamming2(w_rx, w_e0);
    assign w_bm1 = hamming2(w_rx, w_e1);

    viterbi_acs u_acs (
      .i_metric0 (r_metric[P0]),
      .i_metric1 (r_metric[P1]),
      .i_bm0     (w_bm0),
      .i_bm1     (w_bm1),
      .o_metric  (w_metric[g]),
      .o_dec     (w_dec[g])
    );

    assign w_esel  = w_dec[g] ? w_e1 : w_e0;
    assign w_sel_d = w_dec[g] ? r_surv_data[P1] : r_surv_data[P0];
    assign w_sel_c = w_dec[g] ? r_surv_code[P1] : r_surv_code[P0];
    assign w_cpair = {w_esel, {(CW_W-2){1'b0}}} >> {r_step, 1'b0};

    assign w_surv_data[g] = (w_sel_d & ~w_dmask) | (U ? w_dmask : '0);
    assign w_surv_code[g] = (w_sel_c & ~w_cmask) | w_cpair;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (w_new_blk) w_next = ST_LOAD;
      ST_LOAD:          w_next = ST_ACS;
      ST_ACS:           if (r_step == 4'(N_SYM-1)) w_next = ST_FINISH;
      ST_FINISH:        w_next = ST_DONE;
      default:          w_next = ST_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_tmp    <= '0;
      r_step      <= '0;
      r_metric    <= '0;
      r_surv_data <= '0;
      r_surv_code <= '0;
      data        <= '0;
      best_path   <= '0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_in_tmp    <= in;
          // Encoder starts in state 0; other states are unreachable.
          r_metric    <= {{(N_STATE-1){METRIC_MAX}}, {METRIC_W{1'b0}}};
          r_surv_data <= '0;
          r_surv_code <= '0;
          r_step      <= '0;
          done        <= 1'b0;
        end
        ST_ACS: begin
          r_metric    <= w_metric;
          r_surv_data <= w_surv_data;
          r_surv_code <= w_surv_code;
          r_step      <= r_step + 4'd1;
        end
        ST_FINISH: begin
          // Tail bits force the encoder back to state 0.
          data      <= r_surv_data[0];
          best_path <= r_surv_code[0];
        end
        ST_DONE: done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_viterbi.sv
module tb_viterbi;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [27:0] in = '0;
  logic [13:0] data;
  logic [27:0] best_path;
  logic        done;

  int nvec = 0;
  int nerr = 0;
  int c0, c1;

  localparam logic [27:0] CW1 = 28'b1110001011111011111000101100;
  localparam logic [13:0] D1  = 14'b10100100101000;
  localparam logic [27:0] CW2 = 28'b0011010100100010000101001011;
  localparam logic [13:0] D2  = 14'b01101010110100;
  localparam logic [27:0] CW3 = 28'b0000110110011111100010001011;
  localparam logic [13:0] D3  = 14'b00111001010100;

  always #5 clk = ~clk;

  viterbi dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .data      (data),
    .best_path (best_path),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) until done reaches lvl; cyc = posedges consumed.
  task automatic wait_done(input logic lvl, input string tag, output int cyc);
    cyc = 0;
    while (done !== lvl && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(tag, {31'd0, done}, {31'd0, lvl});
  endtask

  initial begin
    // reset values
    #12;
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", {18'd0, data}, 32'd0);
    chk("rst_best", {4'd0, best_path}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // all-zero block after reset is not decoded
    repeat (5) @(posedge clk); #1;
    chk("zero_nodone", {31'd0, done}, 32'd0);
    chk("zero_data", {18'd0, data}, 32'd0);

    // block 1 from IDLE: exact latency 17 edges after the first edge
    in = CW1;
    wait_done(1'b1, "b1_wait", c1);
    chk("b1_latency", c1 - 1, 32'd17);
    chk("b1_data", {18'd0, data}, {18'd0, D1});
    chk("b1_best", {4'd0, best_path}, {4'd0, CW1});

    // block 2 from DONE: done drops, then returns
    in = CW2;
    wait_done(1'b0, "b2_drop", c0);
    chk("b2_drop_lat", c0, 32'd2);
    wait_done(1'b1, "b2_wait", c1);
    chk("b2_latency", c0 + c1 - 1, 32'd17);
    chk("b2_data", {18'd0, data}, {18'd0, D2});
    chk("b2_best", {4'd0, best_path}, {4'd0, CW2});

    // block 3
    in = CW3;
    wait_done(1'b0, "b3_drop", c0);
    wait_done(1'b1, "b3_wait", c1);
    chk("b3_data", {18'd0, data}, {18'd0, D3});
    chk("b3_best", {4'd0, best_path}, {4'd0, CW3});

    // single bit error in block 1 is corrected
    in = CW1 ^ 28'h0100000;
    wait_done(1'b0, "err_drop", c0);
    wait_done(1'b1, "err_wait", c1);
    chk("err_data", {18'd0, data}, {18'd0, D1});
    chk("err_best", {4'd0, best_path}, {4'd0, CW1});

    // input change during ACS is ignored until DONE
    in = CW1;
    repeat (4) @(posedge clk); #1;
    chk("acs_busy", {31'd0, done}, 32'd0);
    in = CW3;
    wait_done(1'b1, "acs_wait1", c1);
    chk("acs_data1", {18'd0, data}, {18'd0, D1});
    chk("acs_best1", {4'd0, best_path}, {4'd0, CW1});
    wait_done(1'b0, "acs_drop", c0);
    wait_done(1'b1, "acs_wait2", c1);
    chk("acs_data2", {18'd0, data}, {18'd0, D3});
    chk("acs_best2", {4'd0, best_path}, {4'd0, CW3});

    // asynchronous reset in the middle of a decode
    in = CW2;
    repeat (6) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_data", {18'd0, data}, 32'd0);
    chk("mrst_best", {4'd0, best_path}, 32'd0);
    @(negedge clk); reset = 1'b1;
    wait_done(1'b1, "mrst_wait", c1);
    chk("mrst_redata", {18'd0, data}, {18'd0, D2});
    chk("mrst_rebest", {4'd0, best_path}, {4'd0, CW2});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
